click_join_n: RTL and testbench

CLICK_JOIN_N -- requirements
Module: click_join_n

---
 rtl/click_join_n.sv | 91 +++++++++
 tb/tb_click_join_n.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/click_join_n.sv
// N-input 2-phase click join: fires once every enabled channel holds a new token and the output is free.
// Optional CLICK_JOIN_SYNC_EN puts 2-flop synchronisers on in_req and out_ack.
module click_join_n #(
    parameter int   CHANNELS   = 3,
    parameter int   WIDTH      = 8,
    parameter logic PHASE_INIT = 1'b0,
    parameter int   CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_req,
    output logic [CHANNELS-1:0]       in_ack,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       en_mask,
    output logic                      out_req,
    input  logic                      out_ack,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]      fire_count
);

    logic [CHANNELS-1:0]       in_req_s;
    logic                      out_ack_s;
    logic [CHANNELS-1:0]       pend;
    logic [CHANNELS-1:0]       lane_ok;
    logic                      out_free;
    logic                      fire;

    logic [CHANNELS-1:0]       ack_reg;
    logic [CHANNELS-1:0]       ack_next;
    logic                      out_req_reg;
    logic [CHANNELS*WIDTH-1:0] data_reg;
    logic [CHANNELS*WIDTH-1:0] data_next;
    logic [CNT_WIDTH-1:0]      cnt_reg;

`ifdef CLICK_JOIN_SYNC_EN
    // Top bit carries out_ack, lower bits carry in_req.
    logic [CHANNELS:0] sync1_reg;
    logic [CHANNELS:0] sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= {(CHANNELS+1){PHASE_INIT}};
            sync2_reg <= {(CHANNELS+1){PHASE_INIT}};
        end else begin
            sync1_reg <= {out_ack, in_req};
            sync2_reg <= sync1_reg;
        end
    end

    assign in_req_s  = sync2_reg[CHANNELS-1:0];
    assign out_ack_s = sync2_reg[CHANNELS];
`else
    assign in_req_s  = in_req;
    assign out_ack_s = out_ack;
`endif

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            assign pend[gi]    = en_mask[gi] & (in_req_s[gi] != ack_reg[gi]);
            // Masked lanes never block the join.
            assign lane_ok[gi] = ~en_mask[gi] | pend[gi];
            // Masked lanes keep their ack so an outstanding token survives.
            assign ack_next[gi] = en_mask[gi] ? in_req_s[gi] : ack_reg[gi];
            assign data_next[gi*WIDTH +: WIDTH] =
                en_mask[gi] ? in_data[gi*WIDTH +: WIDTH] : {WIDTH{1'b0}};
        end
    endgenerate

    assign out_free = (out_ack_s == out_req_reg);
    assign fire     = out_free & (|en_mask) & (&lane_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_reg     <= {CHANNELS{PHASE_INIT}};
            out_req_reg <= PHASE_INIT;
            data_reg    <= '0;
            cnt_reg     <= '0;
        end else if (fire) begin
            ack_reg     <= ack_next;
            out_req_reg <= ~out_req_reg;
            data_reg    <= data_next;
            cnt_reg     <= cnt_reg + CNT_WIDTH'(1);
        end
    end

    assign in_ack     = ack_reg;
    assign out_req    = out_req_reg;
    assign out_data   = data_reg;
    assign fire_count = cnt_reg;

endmodule

// File: tb/tb_click_join_n.sv
// Directed bench for click_join_n: reset, full/partial join, back-pressure, masking, mid-run reset, counter wrap.
// Latency expectations follow CLICK_JOIN_SYNC_EN when it is defined.
module tb_click_join_n;

`ifdef CLICK_JOIN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_req;
    logic [2:0]  in_ack;
    logic [23:0] in_data;
    logic [2:0]  en_mask;
    logic        out_req;
    logic        out_ack;
    logic [23:0] out_data;
    logic [15:0] fire_count;

    logic [1:0]  w_req;
    logic [1:0]  w_in_ack;
    logic        w_out_req;
    logic        w_ack;
    logic [7:0]  w_data;
    logic [1:0]  w_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    click_join_n dut (
        .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_ack(in_ack),
        .in_data(in_data), .en_mask(en_mask), .out_req(out_req),
        .out_ack(out_ack), .out_data(out_data), .fire_count(fire_count)
    );

    click_join_n #(.CHANNELS(2), .WIDTH(4), .CNT_WIDTH(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_req(w_req), .in_ack(w_in_ack),
        .in_data(8'hA5), .en_mask(2'b11), .out_req(w_out_req),
        .out_ack(w_ack), .out_data(w_data), .fire_count(w_count)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        in_req  = 3'b000;
        out_ack = 1'b0;
        en_mask = 3'b111;
        in_data = 24'h0;
        w_req   = 2'b00;
        w_ack   = 1'b0;

        // Reset values, before any clock edge
        #3;
        check_value("rst_out_req", 32'(out_req), 32'h0);
        check_value("rst_in_ack", 32'(in_ack), 32'h0);
        check_value("rst_out_data", 32'(out_data), 32'h0);
        check_value("rst_fire_count", 32'(fire_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        check_value("idle_no_fire", 32'(fire_count), 32'h0);

        // Full join
        in_data = 24'hC3B2A1;
        in_req  = 3'b111;
`ifdef CLICK_JOIN_SYNC_EN
        step(LAT);
        check_value("sync_not_early", 32'(out_req), 32'h0);
        step(1);
`else
        step(1);
`endif
        check_value("full_out_req", 32'(out_req), 32'h1);
        check_value("full_in_ack", 32'(in_ack), 32'h7);
        check_value("full_out_data", 32'(out_data), 32'hC3B2A1);
        check_value("full_count", 32'(fire_count), 32'h1);

        // Back-pressure: output busy until out_ack follows
        in_req = 3'b000;
        step(5);
        check_value("bp_blocked_count", 32'(fire_count), 32'h1);
        check_value("bp_blocked_req", 32'(out_req), 32'h1);
        out_ack = 1'b1;
        step(1 + LAT);
        check_value("bp_out_req", 32'(out_req), 32'h0);
        check_value("bp_count", 32'(fire_count), 32'h2);
        check_value("bp_in_ack", 32'(in_ack), 32'h0);

        // Partial join waits for the last channel
        out_ack = 1'b0;
        in_data = 24'h332211;
        in_req  = 3'b011;
        step(10);
        check_value("partial_wait_count", 32'(fire_count), 32'h2);
        check_value("partial_wait_ack", 32'(in_ack), 32'h0);
        in_req = 3'b111;
        step(1 + LAT);
        check_value("partial_count", 32'(fire_count), 32'h3);
        check_value("partial_out_req", 32'(out_req), 32'h1);
        check_value("partial_in_ack", 32'(in_ack), 32'h7);
        check_value("partial_out_data", 32'(out_data), 32'h332211);

        // Mask 101: lane 1 zeroed, its pending token kept
        out_ack = 1'b1;
        in_data = 24'h556677;
        en_mask = 3'b101;
        in_req  = 3'b000;
        step(1 + LAT);
        check_value("mask_count", 32'(fire_count), 32'h4);
        check_value("mask_out_req", 32'(out_req), 32'h0);
        check_value("mask_in_ack", 32'(in_ack), 32'h2);
        check_value("mask_out_data", 32'(out_data), 32'h550077);

        // Held lane-1 token fires once it is enabled
        out_ack = 1'b0;
        en_mask = 3'b010;
        step(1 + LAT);
        check_value("kept_count", 32'(fire_count), 32'h5);
        check_value("kept_in_ack", 32'(in_ack), 32'h0);
        check_value("kept_out_data", 32'(out_data), 32'h006600);

        // All-zero mask never fires
        out_ack = 1'b1;
        en_mask = 3'b000;
        in_req  = 3'b111;
        step(5);
        check_value("nomask_count", 32'(fire_count), 32'h5);
        check_value("nomask_out_req", 32'(out_req), 32'h1);
        en_mask = 3'b111;
        step(1 + LAT);
        check_value("unmask_count", 32'(fire_count), 32'h6);
        check_value("unmask_out_data", 32'(out_data), 32'h556677);
        check_value("unmask_out_req", 32'(out_req), 32'h0);

        // Asynchronous reset mid-run
        #2;
        rst_n   = 1'b0;
        out_ack = 1'b0;
        #1;
        check_value("mrst_in_ack", 32'(in_ack), 32'h0);
        check_value("mrst_count", 32'(fire_count), 32'h0);
        check_value("mrst_out_data", 32'(out_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1 + LAT);
        check_value("post_rst_count", 32'(fire_count), 32'h1);
        check_value("post_rst_in_ack", 32'(in_ack), 32'h7);

        // 2-bit counter wraps after four fires
        for (int i = 0; i < 4; i++) begin
            w_req = ~w_req;
            step(1 + LAT);
            check_value($sformatf("wrap_count_%0d", i), 32'(w_count), 32'((i + 1) % 4));
            w_ack = ~w_ack;
        end
        check_value("wrap_data", 32'(w_data), 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
